// File: rtl/int_ctrl_sm_pkg.sv
// ---------------------------------------------------------------------------
// int_ctrl_sm_pkg
//   Shared types and constants for the asynchronous-interrupt control
//   sequencer: interrupt cause encoding, sequencer state encoding, default
//   interrupt vectors and the cause-to-vector mapping.
// ---------------------------------------------------------------------------
package int_ctrl_sm_pkg;

  // Latched cause of the interrupt currently being taken.
  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_EXT  = 2'd1,
    INT_DEC  = 2'd2
  } Int_cause;

  // Interrupt entry / exit sequence.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    SAVE    = 3'd2,
    JUMP    = 3'd3,
    HANDLER = 3'd4
  } int_state_e;

  // Default handler entry points (word addresses).
  localparam logic [29:0] VEC_EXT_DEF = 30'h140;
  localparam logic [29:0] VEC_DEC_DEF = 30'h240;

  // Select the handler entry point for a committed cause.
  function automatic logic [29:0] vec_for_cause(
    input Int_cause    c,
    input logic [29:0] vec_ext,
    input logic [29:0] vec_dec
  );
    logic [29:0] v;
    v = vec_ext;
    if (c == INT_DEC) begin
      v = vec_dec;
    end
    return v;
  endfunction

endpackage

// File: rtl/int_ctrl_sm_pending.sv
// ---------------------------------------------------------------------------
// int_ctrl_sm_pending
//   Holds the decrementer-pending flag and priority-encodes the two
//   interrupt sources (external over decrementer).
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   ext_int     : external interrupt level
//   dec_int     : decrementer expiry pulse (sets the pending flag)
//   dec_clr     : decrementer interrupt has been taken (clears the flag)
//   req_cause   : highest-priority pending cause, INT_NONE if nothing pending
// ---------------------------------------------------------------------------
module int_ctrl_sm_pending
  import int_ctrl_sm_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     ext_int,
  input  logic     dec_int,
  input  logic     dec_clr,
  output Int_cause req_cause
);

  logic dec_pend_d;
  logic dec_pend_q;

  // A new expiry arriving in the same cycle the old one is retired must not
  // be lost, so the set is applied after the clear.
  always_comb begin
    dec_pend_d = dec_pend_q;
    if (dec_clr) begin
      dec_pend_d = 1'b0;
    end
    if (dec_int) begin
      dec_pend_d = 1'b1;
    end
  end

  // Reset has priority, which also discards a dec_int coincident with reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_pend_q <= 1'b0;
    end else begin
      dec_pend_q <= dec_pend_d;
    end
  end

  always_comb begin
    req_cause = INT_NONE;
    if (ext_int) begin
      req_cause = INT_EXT;
    end else if (dec_pend_q) begin
      req_cause = INT_DEC;
    end
  end

endmodule

// File: rtl/int_ctrl_sm.sv
// ---------------------------------------------------------------------------
// int_ctrl_sm
//   Asynchronous interrupt sequencer. Waits for an enabled interrupt while no
//   synchronous trap is in progress, drains the pipeline, saves the resume
//   address, redirects fetch to the handler vector and then waits in the
//   handler until return-from-interrupt.
//
// Parameters
//   VEC_EXT     : external-interrupt vector (word address)
//   VEC_DEC     : decrementer-interrupt vector (word address)
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   ext_int     : external interrupt, level
//   dec_int     : decrementer expiry, single-cycle pulse
//   msr_ee      : MSR interrupt enable
//   trap_busy   : synchronous trap sequence in progress (wins ties)
//   pipe_empty  : nothing in flight past decode
//   cur_pc      : resume address
//   rfi         : return-from-interrupt pulse, honoured only in HANDLER
//   jump_ack    : fetch accepted the redirect
//   en_int      : trap enable for decode, low while the sequence owns the pipe
//   srr_we      : write SRR0/SRR1 (SAVE only)
//   srr0        : saved resume address
//   cause       : committed interrupt cause
//   ee_clr      : clear MSR.EE (SAVE only)
//   jump        : redirect request (JUMP only)
//   jump_target : redirect address, zero outside JUMP
// ---------------------------------------------------------------------------
module int_ctrl_sm
  import int_ctrl_sm_pkg::*;
#(
  parameter logic [29:0] VEC_EXT = VEC_EXT_DEF,
  parameter logic [29:0] VEC_DEC = VEC_DEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_int,
  input  logic        dec_int,
  input  logic        msr_ee,
  input  logic        trap_busy,
  input  logic        pipe_empty,
  input  logic [29:0] cur_pc,
  input  logic        rfi,
  input  logic        jump_ack,
  output logic        en_int,
  output logic        srr_we,
  output logic [29:0] srr0,
  output Int_cause    cause,
  output logic        ee_clr,
  output logic        jump,
  output logic [29:0] jump_target
);

  int_state_e  state_d;
  int_state_e  state_q;
  Int_cause    cause_d;
  Int_cause    cause_q;
  logic [29:0] srr0_d;
  logic [29:0] srr0_q;
  logic        dec_clr;
  Int_cause    req_cause;

  int_ctrl_sm_pending u_pending (
    .clk       (clk),
    .reset     (reset),
    .ext_int   (ext_int),
    .dec_int   (dec_int),
    .dec_clr   (dec_clr),
    .req_cause (req_cause)
  );

  // Next state. The cause is committed on IDLE->DRAIN so a later drop of
  // ext_int cannot abort or retarget the sequence.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    srr0_d  = srr0_q;
    dec_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (msr_ee && !trap_busy && (req_cause != INT_NONE)) begin
          state_d = DRAIN;
          cause_d = req_cause;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = SAVE;
        end
      end
      SAVE: begin
        srr0_d  = cur_pc;
        state_d = JUMP;
      end
      JUMP: begin
        if (jump_ack) begin
          state_d = HANDLER;
          dec_clr = (cause_q == INT_DEC);
        end
      end
      HANDLER: begin
        if (rfi) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= INT_NONE;
      srr0_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      srr0_q  <= srr0_d;
    end
  end

  // Outputs decode only the state register (plus cur_pc forwarded during
  // SAVE so srr0 carries the address being written that very cycle).
  always_comb begin
    en_int      = 1'b1;
    srr_we      = 1'b0;
    ee_clr      = 1'b0;
    jump        = 1'b0;
    jump_target = '0;
    srr0        = srr0_q;
    case (state_q)
      DRAIN: begin
        en_int = 1'b0;
      end
      SAVE: begin
        en_int = 1'b0;
        srr_we = 1'b1;
        ee_clr = 1'b1;
        srr0   = cur_pc;
      end
      JUMP: begin
        en_int      = 1'b0;
        jump        = 1'b1;
        jump_target = vec_for_cause(cause_q, VEC_EXT, VEC_DEC);
      end
      default: begin
      end
    endcase
  end

  assign cause = cause_q;

endmodule
